// File: rtl/arb_mux_if.sv
// arb_mux_if: handshake/data bundle between the requesting channels and the
// arbitrated multiplexer.
//   req      [CH]     request per channel (bit i = channel i)
//   data_in  [CH*n]   channel i data at [i*n +: n]
//   done     [1]      shared resource finished the current transaction
//   grant    [CH]     one-hot registered grant
//   sel      [SW]     registered index of the granted channel
//   valid    [1]      a grant is active (|grant)
//   data_out [n]      granted channel's data, zero when nothing is granted
// master: channel/resource side. slave: the arbiter.
interface arb_mux_if #(
    parameter int n  = 32,
    parameter int CH = 4
);
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;

    logic [CH-1:0]   req;
    logic [CH*n-1:0] data_in;
    logic            done;
    logic [CH-1:0]   grant;
    logic [SW-1:0]   sel;
    logic            valid;
    logic [n-1:0]    data_out;

    modport master (
        output req, data_in, done,
        input  grant, sel, valid, data_out
    );

    modport slave (
        input  req, data_in, done,
        output grant, sel, valid, data_out
    );
endinterface

// File: rtl/arb_mux.sv
// arb_mux: CH-channel arbitrated multiplexer in front of one shared resource.
// A registered one-hot grant is chosen (round-robin or fixed priority) and
// held until the resource pulses done or the granted channel drops its
// request; data_out carries the granted channel's data.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active-high
//   bus  arb_mux_if.slave (req, data_in, done in; grant, sel, valid, data_out out)
//
// Parameters: n (data width), CH (channels, >=1), MODE (0 round-robin,
// 1 fixed priority, lowest index wins).
//
// Optional feature ARB_MUX_B2B_EN: when defined, a release edge re-arbitrates
// immediately and loads the next grant on the same edge (no IDLE bubble).
// When undefined, every release passes through IDLE for at least one cycle.
module arb_mux #(
    parameter int n    = 32,
    parameter int CH   = 4,
    parameter int MODE = 0
) (
    input  logic     clk,
    input  logic     rst,
    arb_mux_if.slave bus
);
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    logic [CH-1:0]       grant_q;
    logic [SW-1:0]       sel_q;
    logic [SW-1:0]       ptr_q;

    logic [CH-1:0][n-1:0] din_v;
    logic                 req_sel;
    logic                 rel;
    logic [SW-1:0]        ptr_post;
    logic [SW-1:0]        base;
    logic                 win_any;
    logic [SW-1:0]        win_idx;
    logic [CH-1:0]        win_oh;
    logic [n-1:0]         dout;
    int                   idx;

    assign din_v = bus.data_in;

    // Request line of the currently granted channel (abort detection).
    always_comb begin
        req_sel = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (sel_q == SW'(i)) req_sel = bus.req[i];
        end
    end

    assign rel = (state == BUSY) && (bus.done || !req_sel);

    // Pointer value after a release: one past the released channel, wrapping.
    // Fixed priority never uses the pointer, so it stays at zero.
    always_comb begin
        if (MODE != 0 || int'(sel_q) >= CH - 1) ptr_post = '0;
        else                                    ptr_post = sel_q + SW'(1);
    end

    // While BUSY the only arbitration that can take effect is the back-to-back
    // one at a release edge, which must search from the post-release pointer.
    assign base = (state == BUSY) ? ptr_post : ptr_q;

    // Winner search: walk the channels in priority order starting at base
    // (round-robin) or at 0 (fixed priority); the first requester wins.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = 0; k < CH; k++) begin
            idx = (MODE != 0) ? k : int'(base) + k;
            if (idx >= CH) idx = idx - CH;
            for (int j = 0; j < CH; j++) begin
                if (!win_any && j == idx && bus.req[j]) begin
                    win_any = 1'b1;
                    win_idx = SW'(j);
                end
            end
        end
    end

    always_comb begin
        win_oh = '0;
        for (int j = 0; j < CH; j++) begin
            if (win_idx == SW'(j)) win_oh[j] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // done is meaningless here and deliberately not looked at.
                    if (win_any) begin
                        grant_q <= win_oh;
                        sel_q   <= win_idx;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    // Grant is frozen until release; done and abort together
                    // still count as a single release.
                    if (rel) begin
                        ptr_q <= ptr_post;
`ifdef ARB_MUX_B2B_EN
                        if (win_any) begin
                            grant_q <= win_oh;
                            sel_q   <= win_idx;
                        end else begin
                            grant_q <= '0;
                            state   <= IDLE;
                        end
`else
                        grant_q <= '0;
                        state   <= IDLE;
`endif
                    end
                end
                default: begin
                    grant_q <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Output mux; forced to zero whenever nothing is granted.
    always_comb begin
        dout = '0;
        if (|grant_q) begin
            for (int i = 0; i < CH; i++) begin
                if (sel_q == SW'(i)) dout = din_v[i];
            end
        end
    end

    assign bus.grant    = grant_q;
    assign bus.sel      = sel_q;
    assign bus.valid    = |grant_q;
    assign bus.data_out = dout;
endmodule
